// File: rtl/gru_sequence_driver_pkg.sv
// Shared types and helpers for the GRU sequence driver and its latency timer.
package gru_sequence_driver_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    OUT
  } gru_drv_state_t;

  localparam int GRU_WORD_W = 32;
  typedef logic signed [GRU_WORD_W-1:0] gru_word_t;

  // Width needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gru_sequence_driver_if.sv
// Input stream, cell bus and hidden-state stream of the GRU sequence driver.
// The master modport is the driver's view; slave is the surrounding cell/stream side.
interface gru_sequence_driver_if #(
  parameter int WIDTH  = 32,
  parameter int x_SIZE = 32,
  parameter int h_SIZE = 32
);

  logic [x_SIZE-1:0][WIDTH-1:0] x_in;
  logic                         x_valid;
  logic                         x_ready;
  logic [x_SIZE-1:0][WIDTH-1:0] cell_x_t;
  logic [h_SIZE-1:0][WIDTH-1:0] cell_h_t_minus_1;
  logic [h_SIZE-1:0][WIDTH-1:0] cell_h_t;
  logic [h_SIZE-1:0][WIDTH-1:0] h_out;
  logic                         h_valid;
  logic                         h_ready;
  logic                         h_last;

  modport master (
    input  x_in, x_valid, cell_h_t, h_ready,
    output x_ready, cell_x_t, cell_h_t_minus_1, h_out, h_valid, h_last
  );

  modport slave (
    output x_in, x_valid, cell_h_t, h_ready,
    input  x_ready, cell_x_t, cell_h_t_minus_1, h_out, h_valid, h_last
  );

endinterface

// File: rtl/gru_sequence_driver_latency_timer.sv
// Counts the GRU cell pipeline latency; o_done is high in the cycle before the
// capture edge, i.e. the edge CELL_LATENCY+1 cycles after the start edge.
module gru_sequence_driver_latency_timer
  import gru_sequence_driver_pkg::*;
#(
  parameter int CELL_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_done
);

  localparam int LAT_W = cnt_width(CELL_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CELL_LATENCY);

  logic             r_run;
  logic [LAT_W-1:0] r_lat_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run     <= 1'b0;
      r_lat_cnt <= '0;
    end else if (i_start) begin
      r_run     <= 1'b1;
      r_lat_cnt <= '0;
    end else if (r_run) begin
      if (r_lat_cnt == LAT_LAST) begin
        r_run <= 1'b0;
      end else begin
        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      end
    end
  end

  assign o_done = r_run && (r_lat_cnt == LAT_LAST);

endmodule

// File: rtl/gru_sequence_driver.sv
// Recurrence controller stepping one GRU cell through a SEQ_LEN-long sequence.
// Build option GRU_EMIT_ALL_STEPS_EN: emit h_t after every step, not only the final one.
module gru_sequence_driver
  import gru_sequence_driver_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int NFRAC        = 10,
  parameter int x_SIZE       = 32,
  parameter int h_SIZE       = 32,
  parameter int SEQ_LEN      = 8,
  parameter int CELL_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  gru_sequence_driver_if.master bus,
  output logic                  o_busy
);

  localparam int STEP_W = cnt_width(SEQ_LEN);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);

  if (NFRAC >= WIDTH || SEQ_LEN < 1 || CELL_LATENCY < 0) begin : g_bad_params
    $error("gru_sequence_driver: illegal NFRAC, SEQ_LEN or CELL_LATENCY");
  end

  gru_drv_state_t               r_state;
  gru_drv_state_t               w_next;
  logic [STEP_W-1:0]            r_step;
  logic [x_SIZE-1:0][WIDTH-1:0] r_x;
  logic [h_SIZE-1:0][WIDTH-1:0] r_h;

  logic w_accept;
  logic w_done;
  logic w_capture;
  logic w_handshake;
  logic w_final;
  logic w_step_adv;
  logic w_seq_end;
  logic w_hvalid;

  // x_ready is masked by reset so nothing is accepted while reset is held.
  assign w_final     = (r_step == LAST_STEP);
  assign bus.x_ready = (r_state == IDLE) && !reset;
  assign w_accept    = bus.x_valid && bus.x_ready;
  assign w_capture   = (r_state == WAIT) && w_done;
  assign w_hvalid    = (r_state == OUT);
  assign w_handshake = w_hvalid && bus.h_ready;
  assign w_seq_end   = w_handshake && w_final;

`ifdef GRU_EMIT_ALL_STEPS_EN
  assign w_step_adv = w_handshake && !w_final;
`else
  assign w_step_adv = w_capture && !w_final;
`endif

  gru_sequence_driver_latency_timer #(
    .CELL_LATENCY (CELL_LATENCY)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept),
    .o_done  (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = WAIT;
      WAIT: begin
        if (w_done) begin
`ifdef GRU_EMIT_ALL_STEPS_EN
          w_next = OUT;
`else
          w_next = w_final ? OUT : IDLE;
`endif
        end
      end
      OUT:  if (bus.h_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The hidden state is only cleared once the final result has been taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step <= '0;
      r_x    <= '0;
      r_h    <= '0;
    end else begin
      if (w_accept) begin
        r_x <= bus.x_in;
      end
      if (w_capture) begin
        r_h <= bus.cell_h_t;
      end
      if (w_seq_end) begin
        r_step <= '0;
        r_h    <= '0;
      end else if (w_step_adv) begin
        r_step <= r_step + STEP_W'(1);
      end
    end
  end

  assign bus.cell_x_t         = r_x;
  assign bus.cell_h_t_minus_1 = r_h;
  assign bus.h_valid          = w_hvalid;
  assign bus.h_out            = w_hvalid ? r_h : '0;
  assign o_busy               = (r_state != IDLE);

`ifdef GRU_EMIT_ALL_STEPS_EN
  assign bus.h_last = w_hvalid && w_final;
`else
  assign bus.h_last = w_hvalid;
`endif

endmodule
